// File: rtl/ps2_key_pkg.sv
// ps2_key_pkg: shared types and constants for the PS/2 key-event controller.
// Holds the decoder state enum, set-2 prefix/control byte values, the
// 16-bit key-event layout and the default MMIO addresses.
package ps2_key_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_E0,
        ST_F0,
        ST_E0F0,
        ST_SKIP
    } key_state_t;

    localparam logic [7:0] BYTE_E0 = 8'hE0;
    localparam logic [7:0] BYTE_F0 = 8'hF0;
    localparam logic [7:0] BYTE_E1 = 8'hE1;
    localparam logic [7:0] BYTE_AA = 8'hAA;
    localparam logic [7:0] BYTE_FA = 8'hFA;
    localparam logic [7:0] BYTE_EE = 8'hEE;
    localparam logic [7:0] BYTE_FE = 8'hFE;
    localparam logic [7:0] BYTE_FF = 8'hFF;
    localparam logic [7:0] BYTE_12 = 8'h12;

    // Pause arrives as E1 followed by seven more bytes that carry no extra information.
    localparam logic [2:0] PAUSE_SKIP = 3'd7;

    localparam int EV_WIDTH    = 16;
    localparam int EV_DOWN_BIT = 15;
    localparam int EV_EXT_BIT  = 8;

    localparam logic [31:0] PS2_ADDR_DEFAULT = 32'hA000_0060;
    localparam logic [31:0] KEY_ADDR_DEFAULT = 32'hA000_0064;

    function automatic logic [EV_WIDTH-1:0] make_event(input logic down, input logic ext,
                                                       input logic [7:0] code);
        logic [EV_WIDTH-1:0] ev;
        ev              = '0;
        ev[EV_DOWN_BIT] = down;
        ev[EV_EXT_BIT]  = ext;
        ev[7:0]         = code;
        return ev;
    endfunction

    // Keyboard status/acknowledge bytes that never describe a key.
    function automatic logic is_ignored(input logic [7:0] b);
        return (b inside {BYTE_AA, BYTE_FA, BYTE_EE, BYTE_FE, BYTE_FF, 8'h00});
    endfunction

endpackage

// File: rtl/ps2_key_evq.sv
// ps2_key_evq: count-based synchronous FIFO holding decoded key events.
// Pointers wrap naturally; full and empty are told apart by the count.
module ps2_key_evq
    import ps2_key_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = EV_WIDTH
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       din,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != FULL_COUNT) || do_pop);
    assign head    = mem[rd_ptr];

    // Event storage; contents are only meaningful below the count, so no reset.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointer and occupancy bookkeeping; a simultaneous push and pop leaves the count alone.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ps2_key_ctrl.sv
// ps2_key_ctrl: polls the PS/2 receiver, folds set-2 prefix bytes into whole
// key events and queues them for the CPU.
// Optional build macro PS2_KEY_REPEAT_FILTER_EN: keep a pressed-key map and
// drop typematic repeat makes of keys that are already down.
module ps2_key_ctrl
    import ps2_key_pkg::*;
#(
    parameter int unsigned POLL_DIV  = 16,
    parameter int unsigned EVQ_DEPTH = 16,
    parameter logic [31:0] PS2_ADDR  = PS2_ADDR_DEFAULT,
    parameter logic [31:0] KEY_ADDR  = KEY_ADDR_DEFAULT
) (
    input  logic                       clock,
    input  logic                       reset,
    output logic                       ps2_rvalid,
    output logic [31:0]                ps2_raddr,
    input  logic [31:0]                ps2_rdata,
    input  logic                       cpu_rvalid,
    input  logic [31:0]                cpu_raddr,
    output logic [31:0]                cpu_rdata,
    output logic [$clog2(EVQ_DEPTH):0] evq_count
);

    localparam int CW = $clog2(EVQ_DEPTH) + 1;
    localparam logic [15:0]   POLL_LAST  = 16'(POLL_DIV - 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(EVQ_DEPTH);

    logic [15:0]         poll_cnt;
    logic                run_q;
    logic                at_wrap;
    logic                evq_full;
    logic                poll_fire;
    logic [7:0]          rx_byte;
    key_state_t          state_q;
    key_state_t          state_d;
    logic [2:0]          skip_q;
    logic [2:0]          skip_d;
    logic                raw_push;
    logic                raw_is_pause;
    logic [EV_WIDTH-1:0] raw_event;
    logic                ev_push;
    logic                cpu_hit;
    logic                evq_nonempty;
    logic                ev_pop;
    logic [EV_WIDTH-1:0] evq_head;
    logic                unused_rdata_hi;

    assign at_wrap         = (poll_cnt == POLL_LAST);
    assign evq_full        = (evq_count == FULL_COUNT);
    assign poll_fire       = run_q && at_wrap && !evq_full;
    assign ps2_rvalid      = poll_fire;
    assign ps2_raddr       = poll_fire ? PS2_ADDR : 32'h0;
    assign rx_byte         = ps2_rdata[7:0];
    assign unused_rdata_hi = ^ps2_rdata[31:8];

    // Poll divider; it parks on its last value while the queue is full so the poll fires as soon as room appears.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            poll_cnt <= '0;
            run_q    <= 1'b0;
        end else begin
            run_q <= 1'b1;
            if (at_wrap) begin
                if (!evq_full) begin
                    poll_cnt <= '0;
                end
            end else begin
                poll_cnt <= poll_cnt + 16'd1;
            end
        end
    end

    // Prefix decoder: consumes one polled byte per poll and decides whether it completes an event.
    always_comb begin
        state_d      = state_q;
        skip_d       = skip_q;
        raw_push     = 1'b0;
        raw_is_pause = 1'b0;
        raw_event    = '0;
        if (poll_fire && (rx_byte != 8'h00)) begin
            case (state_q)
                ST_IDLE: begin
                    if (rx_byte == BYTE_E0) begin
                        state_d = ST_E0;
                    end else if (rx_byte == BYTE_F0) begin
                        state_d = ST_F0;
                    end else if (rx_byte == BYTE_E1) begin
                        state_d = ST_SKIP;
                        skip_d  = PAUSE_SKIP;
                    end else if (!is_ignored(rx_byte)) begin
                        raw_push  = 1'b1;
                        raw_event = make_event(1'b1, 1'b0, rx_byte);
                    end
                end
                ST_E0: begin
                    if (rx_byte == BYTE_F0) begin
                        state_d = ST_E0F0;
                    end else if (rx_byte != BYTE_E0) begin
                        state_d = ST_IDLE;
                        if (rx_byte != BYTE_12) begin
                            raw_push  = 1'b1;
                            raw_event = make_event(1'b1, 1'b1, rx_byte);
                        end
                    end
                end
                ST_F0: begin
                    if (rx_byte != BYTE_F0) begin
                        state_d   = ST_IDLE;
                        raw_push  = 1'b1;
                        raw_event = make_event(1'b0, 1'b0, rx_byte);
                    end
                end
                ST_E0F0: begin
                    state_d = ST_IDLE;
                    if (rx_byte != BYTE_12) begin
                        raw_push  = 1'b1;
                        raw_event = make_event(1'b0, 1'b1, rx_byte);
                    end
                end
                ST_SKIP: begin
                    skip_d = skip_q - 3'd1;
                    if (skip_q == 3'd1) begin
                        state_d      = ST_IDLE;
                        raw_push     = 1'b1;
                        raw_is_pause = 1'b1;
                        raw_event    = make_event(1'b1, 1'b1, BYTE_E1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Decoder state and Pause skip count; reset throws away any half-received prefix.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            skip_q  <= '0;
        end else begin
            state_q <= state_d;
            skip_q  <= skip_d;
        end
    end

`ifdef PS2_KEY_REPEAT_FILTER_EN
    logic [511:0] pressed_q;
    logic [8:0]   map_idx;
    logic         filt_drop;

    assign map_idx   = {raw_event[EV_EXT_BIT], raw_event[7:0]};
    assign filt_drop = raw_push && !raw_is_pause && raw_event[EV_DOWN_BIT] && pressed_q[map_idx];
    assign ev_push   = raw_push && !filt_drop;

    // Pressed-key map: makes set their bit, breaks clear it; Pause never touches it.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pressed_q <= '0;
        end else if (ev_push && !raw_is_pause) begin
            pressed_q[map_idx] <= raw_event[EV_DOWN_BIT];
        end
    end
`else
    logic unused_pause;

    assign unused_pause = raw_is_pause;
    assign ev_push      = raw_push;
`endif

    assign cpu_hit      = (cpu_raddr == KEY_ADDR);
    assign evq_nonempty = (evq_count != '0);
    assign ev_pop       = cpu_rvalid && cpu_hit && evq_nonempty;
    assign cpu_rdata    = (cpu_hit && evq_nonempty) ? {16'h0, evq_head} : 32'h0;

    ps2_key_evq #(
        .DEPTH (EVQ_DEPTH),
        .WIDTH (EV_WIDTH)
    ) u_evq (
        .clock (clock),
        .reset (reset),
        .push  (ev_push),
        .din   (raw_event),
        .pop   (ev_pop),
        .head  (evq_head),
        .count (evq_count)
    );

endmodule

// File: tb/tb_ps2_key_ctrl.sv
// tb_ps2_key_ctrl: directed self-checking bench for ps2_key_ctrl with a
// small pop-on-read receiver model (POLL_DIV=4, EVQ_DEPTH=2).
module tb_ps2_key_ctrl;

    localparam int unsigned POLL_DIV  = 4;
    localparam int unsigned EVQ_DEPTH = 2;
    localparam logic [31:0] PS2_ADDR  = 32'hA000_0060;
    localparam logic [31:0] KEY_ADDR  = 32'hA000_0064;

    logic        clock;
    logic        reset;
    logic        ps2_rvalid;
    logic [31:0] ps2_raddr;
    logic [31:0] ps2_rdata;
    logic        cpu_rvalid;
    logic [31:0] cpu_raddr;
    logic [31:0] cpu_rdata;
    logic [1:0]  evq_count;

    int errors = 0;
    int checks = 0;

    logic [7:0] rx_mem [64];
    int         rx_wr = 0;
    int         rx_rd = 0;

    ps2_key_ctrl #(
        .POLL_DIV  (POLL_DIV),
        .EVQ_DEPTH (EVQ_DEPTH),
        .PS2_ADDR  (PS2_ADDR),
        .KEY_ADDR  (KEY_ADDR)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .ps2_rvalid (ps2_rvalid),
        .ps2_raddr  (ps2_raddr),
        .ps2_rdata  (ps2_rdata),
        .cpu_rvalid (cpu_rvalid),
        .cpu_raddr  (cpu_raddr),
        .cpu_rdata  (cpu_rdata),
        .evq_count  (evq_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Receiver model: head byte shown combinationally, popped on a read strobe.
    assign ps2_rdata = (rx_rd != rx_wr) ? {24'h0, rx_mem[rx_rd[5:0]]} : 32'h0;

    // Receiver pop on each poll that finds a byte waiting.
    always @(posedge clock) begin
        if (ps2_rvalid && (rx_rd != rx_wr)) begin
            rx_rd <= rx_rd + 1;
        end
    end

    task automatic enqueue(input logic [7:0] b);
        rx_mem[rx_wr[5:0]] = b;
        rx_wr = rx_wr + 1;
    endtask

    // Waits for the next poll cycle and offers byte b to it; returns at that poll's negedge.
    task automatic send_byte(input logic [7:0] b);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clock);
            if (ps2_rvalid) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("[TB] FAIL poll_timeout byte=%02h: ps2_rvalid stayed 0 for 40 cycles, required a poll", b);
        end
        enqueue(b);
    endtask

    // One-cycle CPU read of KEY_ADDR; data is the value seen during the read cycle.
    task automatic cpu_pop(output logic [31:0] data);
        cpu_raddr  = KEY_ADDR;
        cpu_rvalid = 1'b1;
        #1 data = cpu_rdata;
        @(negedge clock);
        cpu_rvalid = 1'b0;
    endtask

    task automatic test_reset;
        reset      = 1'b0;
        cpu_rvalid = 1'b0;
        cpu_raddr  = KEY_ADDR;
        repeat (3) @(negedge clock);
        checks++; if (ps2_rvalid !== 1'b0) begin errors++; $display("[TB] FAIL reset_rvalid: got %b required 0", ps2_rvalid); end
        checks++; if (ps2_raddr !== 32'h0) begin errors++; $display("[TB] FAIL reset_raddr: got %h required 0", ps2_raddr); end
        checks++; if (cpu_rdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_rdata: got %h required 0", cpu_rdata); end
        checks++; if (evq_count !== 2'd0) begin errors++; $display("[TB] FAIL reset_count: got %0d required 0", evq_count); end
        reset = 1'b1;
    endtask

    task automatic test_make_break;
        logic [31:0] d;
        send_byte(8'h1C);
        checks++; if (ps2_raddr !== PS2_ADDR) begin errors++; $display("[TB] FAIL poll_raddr: got %h required %h", ps2_raddr, PS2_ADDR); end
        checks++; if (evq_count !== 2'd0) begin errors++; $display("[TB] FAIL make_latency_count: got %0d required 0", evq_count); end
        @(negedge clock);
        checks++; if (cpu_rdata !== 32'h801C) begin errors++; $display("[TB] FAIL make_event: got %h required 0000801c", cpu_rdata); end
        checks++; if (evq_count !== 2'd1) begin errors++; $display("[TB] FAIL make_count: got %0d required 1", evq_count); end
        send_byte(8'hF0);
        @(negedge clock);
        checks++; if (evq_count !== 2'd1) begin errors++; $display("[TB] FAIL f0_prefix_count: got %0d required 1", evq_count); end
        send_byte(8'h1C);
        @(negedge clock);
        checks++; if (evq_count !== 2'd2) begin errors++; $display("[TB] FAIL break_count: got %0d required 2", evq_count); end
        checks++; if (cpu_rdata !== 32'h801C) begin errors++; $display("[TB] FAIL head_kept: got %h required 0000801c", cpu_rdata); end
        cpu_pop(d);
        checks++; if (d !== 32'h801C) begin errors++; $display("[TB] FAIL pop_make: got %h required 0000801c", d); end
        checks++; if (cpu_rdata !== 32'h001C) begin errors++; $display("[TB] FAIL break_event: got %h required 0000001c", cpu_rdata); end
        cpu_pop(d);
        checks++; if (evq_count !== 2'd0) begin errors++; $display("[TB] FAIL drain_count: got %0d required 0", evq_count); end
        checks++; if (cpu_rdata !== 32'h0) begin errors++; $display("[TB] FAIL empty_rdata: got %h required 0", cpu_rdata); end
    endtask

    task automatic test_extended;
        logic [31:0] d;
        send_byte(8'hE0);
        send_byte(8'h75);
        @(negedge clock);
        checks++; if (cpu_rdata !== 32'h8175) begin errors++; $display("[TB] FAIL ext_make: got %h required 00008175", cpu_rdata); end
        cpu_pop(d);
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h75);
        @(negedge clock);
        checks++; if (cpu_rdata !== 32'h0175) begin errors++; $display("[TB] FAIL ext_break: got %h required 00000175", cpu_rdata); end
        cpu_pop(d);
        send_byte(8'hE0);
        send_byte(8'h12);
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h12);
        @(negedge clock);
        checks++; if (evq_count !== 2'd0) begin errors++; $display("[TB] FAIL fake_shift_count: got %0d required 0", evq_count); end
    endtask

    task automatic test_pause;
        logic [31:0] d;
        logic [7:0]  seq [8];
        seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
        for (int i = 0; i < 7; i++) send_byte(seq[i]);
        @(negedge clock);
        checks++; if (evq_count !== 2'd0) begin errors++; $display("[TB] FAIL pause_early: got %0d required 0", evq_count); end
        send_byte(seq[7]);
        @(negedge clock);
        checks++; if (evq_count !== 2'd1) begin errors++; $display("[TB] FAIL pause_count: got %0d required 1", evq_count); end
        checks++; if (cpu_rdata !== 32'h81E1) begin errors++; $display("[TB] FAIL pause_event: got %h required 000081e1", cpu_rdata); end
        cpu_pop(d);
        send_byte(8'h1C);
        @(negedge clock);
        checks++; if (cpu_rdata !== 32'h801C) begin errors++; $display("[TB] FAIL after_pause: got %h required 0000801c", cpu_rdata); end
        cpu_pop(d);
    endtask

    task automatic test_full;
        logic [31:0] d;
        int          polls;
        bit          seen;
        enqueue(8'h1B);
        enqueue(8'h32);
        enqueue(8'h21);
        polls = ps2_rvalid ? 1 : 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            if (ps2_rvalid) polls++;
        end
        checks++; if (polls != 2) begin errors++; $display("[TB] FAIL full_poll_count: got %0d required 2", polls); end
        checks++; if (evq_count !== 2'd2) begin errors++; $display("[TB] FAIL full_count: got %0d required 2", evq_count); end
        checks++; if ((rx_wr - rx_rd) != 1) begin errors++; $display("[TB] FAIL full_rx_left: got %0d required 1", rx_wr - rx_rd); end
        cpu_pop(d);
        checks++; if (d !== 32'h801B) begin errors++; $display("[TB] FAIL full_pop: got %h required 0000801b", d); end
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (ps2_rvalid) seen = 1'b1;
            else @(negedge clock);
        end
        checks++; if (!seen) begin errors++; $display("[TB] FAIL refill_poll: got no poll required one within 10 cycles"); end
        @(negedge clock);
        checks++; if (evq_count !== 2'd2) begin errors++; $display("[TB] FAIL refill_count: got %0d required 2", evq_count); end
        checks++; if (cpu_rdata !== 32'h8032) begin errors++; $display("[TB] FAIL refill_head: got %h required 00008032", cpu_rdata); end
        cpu_pop(d);
        cpu_pop(d);
        checks++; if (d !== 32'h8021) begin errors++; $display("[TB] FAIL third_event: got %h required 00008021", d); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] d;
        send_byte(8'h2A);
        send_byte(8'h2B);
        cpu_raddr  = KEY_ADDR;
        cpu_rvalid = 1'b1;
        #1;
        checks++; if (cpu_rdata !== 32'h802A) begin errors++; $display("[TB] FAIL simul_old: got %h required 0000802a", cpu_rdata); end
        @(negedge clock);
        cpu_rvalid = 1'b0;
        checks++; if (evq_count !== 2'd1) begin errors++; $display("[TB] FAIL simul_count: got %0d required 1", evq_count); end
        checks++; if (cpu_rdata !== 32'h802B) begin errors++; $display("[TB] FAIL simul_new: got %h required 0000802b", cpu_rdata); end
        cpu_raddr  = PS2_ADDR;
        cpu_rvalid = 1'b1;
        #1;
        checks++; if (cpu_rdata !== 32'h0) begin errors++; $display("[TB] FAIL wrong_addr_data: got %h required 0", cpu_rdata); end
        @(negedge clock);
        cpu_rvalid = 1'b0;
        cpu_raddr  = KEY_ADDR;
        #1;
        checks++; if (evq_count !== 2'd1) begin errors++; $display("[TB] FAIL wrong_addr_nopop: got %0d required 1", evq_count); end
        cpu_pop(d);
        cpu_rvalid = 1'b1;
        #1;
        checks++; if (cpu_rdata !== 32'h0) begin errors++; $display("[TB] FAIL empty_read: got %h required 0", cpu_rdata); end
        @(negedge clock);
        cpu_rvalid = 1'b0;
        checks++; if (evq_count !== 2'd0) begin errors++; $display("[TB] FAIL empty_read_count: got %0d required 0", evq_count); end
        send_byte(8'h3A);
        @(negedge clock);
        checks++; if (cpu_rdata !== 32'h803A) begin errors++; $display("[TB] FAIL post_empty_event: got %h required 0000803a", cpu_rdata); end
        cpu_pop(d);
    endtask

    task automatic test_reset_mid;
        logic [31:0] d;
        send_byte(8'h4B);
        send_byte(8'hE0);
        @(negedge clock);
        checks++; if (evq_count !== 2'd1) begin errors++; $display("[TB] FAIL pre_reset_count: got %0d required 1", evq_count); end
        #2 reset = 1'b0;
        #1;
        checks++; if (evq_count !== 2'd0) begin errors++; $display("[TB] FAIL async_flush: got %0d required 0", evq_count); end
        checks++; if (cpu_rdata !== 32'h0) begin errors++; $display("[TB] FAIL async_rdata: got %h required 0", cpu_rdata); end
        @(negedge clock);
        reset = 1'b1;
        send_byte(8'h75);
        @(negedge clock);
        checks++; if (cpu_rdata !== 32'h8075) begin errors++; $display("[TB] FAIL prefix_discarded: got %h required 00008075", cpu_rdata); end
        cpu_pop(d);
    endtask

    task automatic test_repeat;
        logic [31:0] d;
`ifdef PS2_KEY_REPEAT_FILTER_EN
        send_byte(8'h1C);
        send_byte(8'h1C);
        send_byte(8'h1C);
        @(negedge clock);
        checks++; if (evq_count !== 2'd1) begin errors++; $display("[TB] FAIL repeat_filtered: got %0d required 1", evq_count); end
        send_byte(8'hF0);
        send_byte(8'h1C);
        @(negedge clock);
        checks++; if (evq_count !== 2'd2) begin errors++; $display("[TB] FAIL repeat_break_count: got %0d required 2", evq_count); end
        cpu_pop(d);
        checks++; if (d !== 32'h801C) begin errors++; $display("[TB] FAIL repeat_make: got %h required 0000801c", d); end
        cpu_pop(d);
        checks++; if (d !== 32'h001C) begin errors++; $display("[TB] FAIL repeat_break: got %h required 0000001c", d); end
`else
        send_byte(8'h1C);
        send_byte(8'h1C);
        @(negedge clock);
        checks++; if (evq_count !== 2'd2) begin errors++; $display("[TB] FAIL repeat_count: got %0d required 2", evq_count); end
        cpu_pop(d);
        checks++; if (d !== 32'h801C) begin errors++; $display("[TB] FAIL repeat_first: got %h required 0000801c", d); end
        cpu_pop(d);
        checks++; if (d !== 32'h801C) begin errors++; $display("[TB] FAIL repeat_second: got %h required 0000801c", d); end
`endif
    endtask

    initial begin
        $display("[TB] ps2_key_ctrl bench start");
        test_reset;
        test_make_break;
        test_extended;
        test_pause;
        test_full;
        test_back_to_back;
        test_reset_mid;
        test_repeat;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
